uart_rx_param: RTL

Parametrised UART receiver and the successor to the fixed 8N1 receiver used on the 50 MHz board designs. It supports configurable data width, parity mode, stop-bit count and 3-sample majority voting. It reports parity and framing errors alongside each received word. It sits between the board Rx pin and the byte-consumer logic.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_rx_sampler.sv | 39 +++
 rtl/uart_rx_param.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM encoding, baud divider helper.
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK
  } rx_state_e;

  function automatic int bit_cnt(input longint clk_hz, input longint baud);
    return int'(clk_hz / baud);
  endfunction
endpackage

// File: rtl/uart_rx_sampler.sv
// Rx synchroniser, falling-edge detect and 3-sample majority vote around mid-bit.
module uart_rx_sampler #(
  parameter int CNT_W = 13,
  parameter int MID   = 2604
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Rx,
  input  logic [CNT_W-1:0] cnt,
  output logic             rx_sync,
  output logic             fall_edge,
  output logic             vote
);
  localparam logic [CNT_W-1:0] SMP0 = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] SMP1 = CNT_W'(MID);

  logic       meta;
  logic       rx_prev;
  logic [1:0] smp;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      meta    <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
      smp     <= 2'b11;
    end else begin
      meta    <= Rx;
      rx_sync <= meta;
      rx_prev <= rx_sync;
      if (cnt == SMP0) smp[0] <= rx_sync;
      if (cnt == SMP1) smp[1] <= rx_sync;
    end
  end

  assign fall_edge = rx_prev & ~rx_sync;
  // Third sample is the live value, so the vote is valid while cnt == MID+1.
  assign vote = (smp[0] & smp[1]) | (smp[0] & rx_sync) | (smp[1] & rx_sync);
endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable width, parity, stop bits; reports
// parity and framing errors with each received word.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Rx,
  output logic [DATA_BITS-1:0] Data_out,
  output logic                 en_data_out,
  output logic                 Parity_err,
  output logic                 Frame_err,
  output logic                 Busy
);
  localparam int BIT_CNT = bit_cnt(CLK_FREQ, BAUD);
  localparam int MID     = BIT_CNT / 2;
  localparam int CW      = $clog2(BIT_CNT);
  localparam int IW      = $clog2(DATA_BITS);

  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || BIT_CNT < 8) begin : g_param_chk
    $fatal(1, "uart_rx_param: illegal parameter combination");
  end

  localparam logic [CW-1:0] CNT_LAST  = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] CNT_VOTE  = CW'(MID + 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);
  localparam logic          ODD       = (PARITY == PAR_ODD);

  rx_state_e            state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err;
  logic                 frm_err;
  logic                 rx_sync;
  logic                 fall_edge;
  logic                 vote;
  logic                 at_vote;
  logic                 at_wrap;
  logic                 frm_now;

  uart_rx_sampler #(.CNT_W(CW), .MID(MID)) u_smp (
    .Clk       (Clk),
    .Reset     (Reset),
    .Rx        (Rx),
    .cnt       (cnt),
    .rx_sync   (rx_sync),
    .fall_edge (fall_edge),
    .vote      (vote)
  );

  assign at_vote = (cnt == CNT_VOTE);
  assign at_wrap = (cnt == CNT_LAST);
  assign frm_now = frm_err | ~vote;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      stop_idx    <= 1'b0;
      shreg       <= '0;
      par_err     <= 1'b0;
      frm_err     <= 1'b0;
      Data_out    <= '0;
      en_data_out <= 1'b0;
      Parity_err  <= 1'b0;
      Frame_err   <= 1'b0;
      Busy        <= 1'b0;
    end else begin
      en_data_out <= 1'b0;
      Parity_err  <= 1'b0;
      Frame_err   <= 1'b0;
      cnt         <= at_wrap ? '0 : cnt + 1'b1;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (fall_edge) begin
            state   <= ST_START;
            Busy    <= 1'b1;
            par_err <= 1'b0;
            frm_err <= 1'b0;
          end
        end
        ST_START: begin
          if (at_vote && vote) begin
            state <= ST_IDLE;
            Busy  <= 1'b0;
          end else if (at_wrap) begin
            state   <= ST_DATA;
            bit_idx <= '0;
          end
        end
        ST_DATA: begin
          if (at_vote) shreg <= {vote, shreg[DATA_BITS-1:1]};
          if (at_wrap) begin
            if (bit_idx == BIT_LAST) begin
              state    <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
              stop_idx <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (at_vote) par_err <= (^shreg) ^ vote ^ ODD;
          if (at_wrap) state <= ST_STOP;
        end
        ST_STOP: begin
          // Final stop bit completes the frame at its vote point, leaving half a
          // bit of slack so a back-to-back start edge is seen from IDLE.
          if (at_vote) begin
            frm_err <= frm_now;
            if (stop_idx == STOP_LAST) begin
              Data_out    <= shreg;
              en_data_out <= 1'b1;
              Parity_err  <= par_err;
              Frame_err   <= frm_now;
              if (frm_now && shreg == '0) begin
                state <= ST_BREAK;
              end else begin
                state <= ST_IDLE;
                Busy  <= 1'b0;
              end
            end
          end else if (at_wrap) begin
            stop_idx <= 1'b1;
          end
        end
        ST_BREAK: begin
          cnt <= '0;
          if (rx_sync) begin
            state <= ST_IDLE;
            Busy  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
